// File: rtl/vec_elem_sequencer.sv
// Lane-serial vector controller: accepts one vector op, computes one element per cycle, returns the result vector.
// Optional macro VEC_SEQ_B2B_EN lets a DONE-state retire edge accept the next operation in the same cycle.
module vec_elem_sequencer #(
    parameter int ELEM_W   = 16,
    parameter int NUM_ELEM = 8,
    parameter int IDX_W    = $clog2(NUM_ELEM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic                         in_bcast,
    input  logic [NUM_ELEM*ELEM_W-1:0]   in_vec_a,
    input  logic [NUM_ELEM*ELEM_W-1:0]   in_vec_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]   out_vec,
    output logic                         out_err,
    output logic                         busy,
    output logic [1:0]                   o_dbg_state
);

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its payload stable while valid=1 and ready=0.

    localparam int VEC_W = NUM_ELEM * ELEM_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [2:0]          r_op;
    logic                r_bcast;
    logic [VEC_W-1:0]    r_vec_a;
    logic [VEC_W-1:0]    r_vec_b;
    logic [VEC_W-1:0]    r_res;
    logic                r_err;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_last;
    logic [ELEM_W-1:0]   w_a;
    logic [ELEM_W-1:0]   w_b;
    logic [ELEM_W-1:0]   w_elem;

    assign w_last   = (r_idx == IDX_W'(NUM_ELEM - 1));
    assign w_accept = in_valid & w_in_ready;

    // Operand element selection for the lane currently being processed.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a = r_vec_a[i*ELEM_W +: ELEM_W];
                w_b = r_vec_b[i*ELEM_W +: ELEM_W];
            end
        end
        if (r_bcast) begin
            w_b = r_vec_b[ELEM_W-1:0];
        end
    end

    // Shift amounts use the full b value; out-of-range shifts fall out naturally as zeros or sign fill.
    always_comb begin
        w_elem = '0;
        case (r_op)
            3'b000:  w_elem = w_a + w_b;
            3'b001:  w_elem = w_a - w_b;
            3'b010:  w_elem = w_a * w_b;
            3'b011:  w_elem = $unsigned($signed(w_a) >>> w_b);
            3'b100:  w_elem = w_a >> w_b;
            3'b101:  w_elem = w_a << w_b;
            3'b110:  w_elem = w_a & w_b;
            default: w_elem = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
`ifdef VEC_SEQ_B2B_EN
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? S_EXEC : S_IDLE;
                end
`else
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_op    <= '0;
            r_bcast <= 1'b0;
            r_vec_a <= '0;
            r_vec_b <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_op    <= in_op;
            r_bcast <= in_bcast;
            r_vec_a <= in_vec_a;
            r_vec_b <= in_vec_b;
            r_res   <= '0;
            r_err   <= (in_op == 3'b111);
        end else if (r_state == S_EXEC) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_res[i*ELEM_W +: ELEM_W] <= w_elem;
                end
            end
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == S_DONE);
    assign out_vec     = r_res;
    assign out_err     = r_err;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Self-checking bench for vec_elem_sequencer: directed cases plus random ops against an element-wise reference model.
module tb_vec_elem_sequencer;

    localparam int EW = 16;
    localparam int NE = 8;
    localparam int VW = EW * NE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic          in_bcast;
    logic [VW-1:0] in_vec_a;
    logic [VW-1:0] in_vec_b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic          out_err;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [VW-1:0] exp_q[$];
    logic          exp_err_q[$];

    vec_elem_sequencer #(.ELEM_W(EW), .NUM_ELEM(NE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_bcast(in_bcast),
        .in_vec_a(in_vec_a), .in_vec_b(in_vec_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_err(out_err),
        .busy(busy), .o_dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: per-element arithmetic from the op table.
    function automatic logic [VW-1:0] model_vec(input logic [2:0] op, input logic bcast,
                                                 input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        logic [EW-1:0] ae, be, re;
        int            sh;
        r = '0;
        for (int i = 0; i < NE; i++) begin
            ae = a[i*EW +: EW];
            be = bcast ? b[EW-1:0] : b[i*EW +: EW];
            sh = int'(be);
            case (op)
                3'd0: re = EW'(int'(ae) + int'(be));
                3'd1: re = EW'(int'(ae) - int'(be) + 65536);
                3'd2: re = EW'(longint'(ae) * longint'(be));
                3'd3: begin
                    if (sh >= EW)         re = ae[EW-1] ? '1 : '0;
                    else if (ae[EW-1])    re = ~((~ae) >> sh);
                    else                  re = ae >> sh;
                end
                3'd4: re = (sh >= EW) ? '0 : (ae >> sh);
                3'd5: re = (sh >= EW) ? '0 : (ae << sh);
                3'd6: re = ae & be;
                default: re = '0;
            endcase
            r[i*EW +: EW] = re;
        end
        return r;
    endfunction

    task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver: offer an op and hold it until accepted; returns at the negedge after the accept edge
    task automatic send(input logic [2:0] op, input logic bcast, input logic [VW-1:0] a, input logic [VW-1:0] b);
        int n;
        exp_q.push_back(model_vec(op, bcast, a, b));
        exp_err_q.push_back(op == 3'd7);
        in_op    = op;
        in_bcast = bcast;
        in_vec_a = a;
        in_vec_b = b;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_bit("accept_in_time", n < 40, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_bcast = 1'($urandom);
        in_vec_a = {4{$urandom}};
        in_vec_b = {4{$urandom}};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_bit("valid_in_time", out_valid, 1'b1);
    endtask

    // scoreboard: hold for 'stall' cycles (optionally poking in_valid), compare, then accept
    task automatic retire(input int stall, input bit poke);
        logic [VW-1:0] e_vec;
        logic          e_err;
        e_vec = exp_q.pop_front();
        e_err = exp_err_q.pop_front();
        for (int k = 0; k < stall; k++) begin
            check_vec("hold_vec", out_vec, e_vec);
            check_bit("hold_valid", out_valid, 1'b1);
            if (poke) begin
                in_valid = 1'b1;
                in_op    = 3'($urandom_range(0, 6));
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        check_vec("out_vec", out_vec, e_vec);
        check_bit("out_err", out_err, e_err);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("valid_drop", out_valid, 1'b0);
        check_bit("busy_drop", busy, 1'b0);
        check_vec("vec_kept", out_vec, e_vec);
    endtask

    task automatic op_run(input logic [2:0] op, input logic bcast, input logic [VW-1:0] a,
                          input logic [VW-1:0] b, input int stall, input bit poke);
        int lat;
        send(op, bcast, a, b);
        wait_valid(lat);
        check_int("latency", lat, NE);
        retire(stall, poke);
    endtask

    initial begin
        logic [VW-1:0] va, vb;
        logic [2:0]    rop;
        int            lat, c1, c2, gap_exp;
        bit            seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_bcast  = 1'b0;
        in_vec_a  = '0;
        in_vec_b  = '0;
        out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_out_vec", out_vec, '0);
        check_bit("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #1;
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_err", out_err, 1'b0);
        @(negedge clk);

        // add with wrap: A[i]=i+1, B[i]=0xFFFF
        for (int i = 0; i < NE; i++) begin
            va[i*EW +: EW] = EW'(i + 1);
            vb[i*EW +: EW] = 16'hFFFF;
        end
        op_run(3'd0, 1'b0, va, vb, 0, 1'b0);
        for (int i = 0; i < NE; i++) begin
            check_int("add_elem", int'(out_vec[i*EW +: EW]), i);
        end

        // reset in the middle of EXEC loses the op
        send(3'd6, 1'b0, {8{16'hFFFF}}, {8{16'h1234}});
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_vec("midrst_out_vec", out_vec, '0);
        check_bit("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        exp_err_q.delete();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check_bit("midrst_no_output", seen, 1'b0);

        // arithmetic right shift with broadcast
        op_run(3'd3, 1'b1, {8{16'h8000}}, {112'd0, 16'd4}, 1, 1'b0);
        check_vec("asr4_const", out_vec, {8{16'hF800}});
        op_run(3'd3, 1'b1, {8{16'h8000}}, {112'd0, 16'd20}, 0, 1'b0);
        check_vec("asr20_const", out_vec, {8{16'hFFFF}});

        // illegal op with backpressure and ignored in_valid pokes
        op_run(3'd7, 1'b0, {4{$urandom}}, {4{$urandom}}, 5, 1'b1);
        check_bit("illegal_err_held", out_err, 1'b1);
        @(negedge clk);
        check_bit("illegal_no_capture", busy, 1'b0);

        // multiply and AND
        op_run(3'd2, 1'b0, {8{16'h0100}}, {8{16'h0101}}, 0, 1'b0);
        check_vec("mul_const", out_vec, {8{16'h0100}});
        op_run(3'd6, 1'b0, {8{16'hF0F0}}, {8{16'h0FF0}}, 2, 1'b0);
        check_vec("and_const", out_vec, {8{16'h00F0}});

        // back-to-back: spacing between consecutive out_valid rises
        send(3'd1, 1'b0, {4{$urandom}}, {4{$urandom}});
        wait_valid(lat);
        c1 = cyc;
        check_vec("b2b_first_vec", out_vec, exp_q.pop_front());
        check_bit("b2b_first_err", out_err, exp_err_q.pop_front());
        out_ready = 1'b1;
        send(3'd5, 1'b0, {4{$urandom}}, {8{16'($urandom_range(0, 18))}});
        out_ready = 1'b0;
        wait_valid(lat);
        c2 = cyc;
`ifdef VEC_SEQ_B2B_EN
        gap_exp = NE + 1;
`else
        gap_exp = NE + 2;
`endif
        check_int("b2b_gap", c2 - c1, gap_exp);
        retire(0, 1'b0);

        // random ops against the model
        for (int t = 0; t < 20; t++) begin
            rop = 3'($urandom_range(0, 7));
            va  = {$urandom, $urandom, $urandom, $urandom};
            if (rop >= 3'd3 && rop <= 3'd5) begin
                for (int i = 0; i < NE; i++) vb[i*EW +: EW] = 16'($urandom_range(0, 20));
            end else begin
                vb = {$urandom, $urandom, $urandom, $urandom};
            end
            op_run(rop, 1'($urandom_range(0, 1)), va, vb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_elem_sequencer.md
Name: vec_elem_sequencer

Overview:
- Lane-serial vector execution controller; the issuing side for the per-element vector ALU operation set.
- Accepts one vector operation (op, vector A, vector B) over a valid/ready handshake and processes it one element per cycle.
- Assembles the element results into a result vector and returns it over a second valid/ready handshake.
- Sits between the vector decode/register-read stage and vector writeback; holds one operation at a time.

Parameters:
- ELEM_W, 16, element width in bits.
- NUM_ELEM, 8, elements per vector; must be ≥2.
- IDX_W, $clog2(NUM_ELEM), element index counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  sequencer can accept an operation.
- in_op  input  3  operation select.
- in_bcast  input  1  1 = use element 0 of in_vec_b for every lane.
- in_vec_a  input  NUM_ELEM*ELEM_W  operand A; element i is bits [i*ELEM_W +: ELEM_W].
- in_vec_b  input  NUM_ELEM*ELEM_W  operand B, same packing as in_vec_a.
- out_valid  output  1  result vector available.
- out_ready  input  1  consumer accepts the result.
- out_vec  output  NUM_ELEM*ELEM_W  result vector, same packing.
- out_err  output  1  illegal op code; qualified by out_valid.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, idx=0.
  - Operand, op and bcast registers cleared.
  - out_vec=0, out_valid=0, out_err=0, busy=0.
  - in_ready=1 as soon as rst_n deasserts.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: capture in_op, in_bcast, in_vec_a, in_vec_b; idx←0; clear result register; go to EXEC.
- EXEC:
  - in_ready=0.
  - Each edge computes element idx and writes it into result slot idx.
  - b_elem = in_bcast ? B[0] : B[idx].
  - idx==NUM_ELEM-1: write the last element, go to DONE, idx←0.
  - Otherwise idx←idx+1.
- DONE:
  - out_valid=1; out_vec and out_err held stable until accepted.
  - On out_ready=1: go to IDLE and drop out_valid.
  - out_vec keeps its last value after acceptance.
- Latency: accept edge E0; element k is written at edge E(k+1); out_valid is high after edge E(NUM_ELEM). Throughput is one op per NUM_ELEM+2 cycles minimum (without the optional feature).
- Op encoding per element (a, b unsigned ELEM_W unless stated; result truncated to ELEM_W):
  - 000 = a+b, wrap.
  - 001 = a−b, wrap.
  - 010 = low ELEM_W bits of a*b.
  - 011 = arithmetic right shift; a is signed; the shift amount is the full b value; b≥ELEM_W gives all sign bits.
  - 100 = logical right shift; b≥ELEM_W gives 0.
  - 101 = logical left shift; b≥ELEM_W gives 0.
  - 110 = a&b.
  - 111 = illegal: every element = 0, out_err=1.
- out_err is 0 for every legal op.
- in_valid in EXEC/DONE is ignored (not captured). The producer must hold its operation until in_ready.
- out_ready while out_valid=0 has no effect.
- Reset mid-EXEC or mid-DONE: the operation is lost with no partial output; rules as reset above.

Optional Feature:
- Macro: VEC_SEQ_B2B_EN.
- Defined:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - A DONE edge with out_ready=1 and in_valid=1 retires the current result and captures the new op in the same edge, going directly to EXEC.
  - Throughput becomes one op per NUM_ELEM+1 cycles.
- Undefined: in_ready is high only in IDLE; DONE always returns through IDLE.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC -> out_valid=0, out_vec=0, busy=0, in_ready=1 immediately after release.
- Add (defaults): op=000, A[i]=i+1, B[i]=0xFFFF -> out_vec[i]=i (wrap); out_valid rises exactly 8 edges after accept; out_err=0.
- Arithmetic shift with broadcast: op=011, bcast=1, A[i]=0x8000, B[0]=4, B[1..7]=0 -> every element 0xF800. Then B[0]=20 -> every element 0xFFFF.
- Illegal op plus backpressure: op=111, out_ready=0 for 5 cycles -> out_vec=0, out_err=1, held stable; in_valid pulses during DONE not captured; released on out_ready=1.
- Multiply/AND: op=010, A[i]=0x0100, B[i]=0x0101 -> 0x0100. Then op=110, A=0xF0F0, B=0x0FF0 -> 0x00F0 per element.
- B2B (VEC_SEQ_B2B_EN defined): in_valid=1 and out_ready=1 during DONE -> new op accepted on the retire edge, next out_valid 9 cycles after the previous one. Macro undefined -> 10 cycles.
